tcp_hdr_parser: RTL and testbench

Receive-side header parser for the TCP offload engine. Consumes the raw Ethernet frame byte stream from the MAC, extracts the connection tuple (MACs, IPv4 addresses, TCP ports), filters out non-IPv4/TCP frames, and drives the connection-table searcher's request interface. It returns the connection ID and error code to the downstream segment logic. It sits directly upstream of the connection-table searcher.

---
 rtl/toe_pkg.sv | 52 +++++
 rtl/tcp_hdr_parser_if.sv | 40 ++++
 rtl/tcp_hdr_parser.sv | 190 +++++++++++++++++++
 tb/tb_tcp_hdr_parser.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/toe_pkg.sv
// rtl/toe_pkg.sv - shared constants, tuple struct and parser state type for the TCP offload engine
package toe_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [7:0]  PROTO_TCP      = 8'h06;

  // Frame byte offsets; *_LO marks the last (least significant) byte of a field
  localparam logic [7:0] OFF_MAC_DST     = 8'd3;
  localparam logic [7:0] OFF_MAC_DST_LO  = 8'd5;
  localparam logic [7:0] OFF_MAC_SRC     = 8'd9;
  localparam logic [7:0] OFF_MAC_SRC_LO  = 8'd11;
  localparam logic [7:0] OFF_ETYPE_HI    = 8'd12;
  localparam logic [7:0] OFF_ETYPE_LO    = 8'd13;
  localparam logic [7:0] OFF_VER_IHL     = 8'd14;
  localparam logic [7:0] OFF_PROTO       = 8'd23;
  localparam logic [7:0] OFF_IP_SRC      = 8'd26;
  localparam logic [7:0] OFF_IP_SRC_LO   = 8'd29;
  localparam logic [7:0] OFF_IP_DST      = 8'd30;
  localparam logic [7:0] OFF_IP_DST_LO   = 8'd33;
  localparam logic [7:0] OFF_PORT_SRC    = 8'd34;
  localparam logic [7:0] OFF_PORT_SRC_LO = 8'd35;
  localparam logic [7:0] OFF_PORT_DST    = 8'd36;
  localparam logic [7:0] OFF_PORT_DST_LO = 8'd37;

  localparam logic [1:0] RQ_IDLE = 2'b00;
  localparam logic [1:0] RQ_OPEN = 2'b01;

  typedef struct packed {
    logic [23:0] mac_src;
    logic [23:0] mac_dst;
    logic [31:0] ip_src;
    logic [31:0] ip_dst;
    logic [15:0] port_src;
    logic [15:0] port_dst;
  } conn_tuple_t;

  typedef enum logic [2:0] {
    HP_IDLE,
    HP_HDR,
    HP_SKIP,
    HP_SETUP,
    HP_REQ,
    HP_RESP
  } hp_state_t;

  // True when a byte offset lies inside a multi-byte field
  function automatic logic in_field(logic [7:0] off, logic [7:0] lo, logic [7:0] hi);
    return (off >= lo) && (off <= hi);
  endfunction

endpackage

// File: rtl/tcp_hdr_parser_if.sv
// rtl/tcp_hdr_parser_if.sv - byte stream, searcher request/response and result signals of the header parser
interface tcp_hdr_parser_if;
  logic [7:0]  hp_in_data;
  logic        hp_in_valid;
  logic        hp_in_sof;
  logic        hp_in_eof;
  logic        hp_in_ready;
  logic [1:0]  hp_rq;
  logic [23:0] hp_mac_src;
  logic [23:0] hp_mac_dst;
  logic [31:0] hp_ip_src;
  logic [31:0] hp_ip_dst;
  logic [15:0] hp_port_src;
  logic [15:0] hp_port_dst;
  logic        hp_rs_done;
  logic [7:0]  hp_rs_error;
  logic [7:0]  hp_rs_id;
  logic        hp_lk_valid;
  logic [7:0]  hp_lk_id;
  logic [7:0]  hp_lk_err;
  logic [15:0] hp_drop_cnt;

  // Parser side
  modport slave (
    input  hp_in_data, hp_in_valid, hp_in_sof, hp_in_eof,
    input  hp_rs_done, hp_rs_error, hp_rs_id,
    output hp_in_ready, hp_rq,
    output hp_mac_src, hp_mac_dst, hp_ip_src, hp_ip_dst, hp_port_src, hp_port_dst,
    output hp_lk_valid, hp_lk_id, hp_lk_err, hp_drop_cnt
  );

  // MAC source / searcher / downstream side
  modport master (
    output hp_in_data, hp_in_valid, hp_in_sof, hp_in_eof,
    output hp_rs_done, hp_rs_error, hp_rs_id,
    input  hp_in_ready, hp_rq,
    input  hp_mac_src, hp_mac_dst, hp_ip_src, hp_ip_dst, hp_port_src, hp_port_dst,
    input  hp_lk_valid, hp_lk_id, hp_lk_err, hp_drop_cnt
  );
endinterface

// File: rtl/tcp_hdr_parser.sv
// rtl/tcp_hdr_parser.sv - Ethernet/IPv4/TCP header parser driving the connection-table searcher
module tcp_hdr_parser #(
  parameter int SETUP_CYC   = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic           hp_clk,
  input  logic           hp_rst_n,
  tcp_hdr_parser_if.slave hp
);
  import toe_pkg::*;

  localparam logic [7:0] SETUP_LAST   = 8'(SETUP_CYC - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  hp_state_t   state_q, state_d;
  logic [7:0]  off_q, off_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bad_q, bad_d;
  logic [7:0]  et_hi_q, et_hi_d;
  conn_tuple_t tup_q, tup_d;
  logic [7:0]  lk_id_q, lk_id_d;
  logic [7:0]  lk_err_q, lk_err_d;
  logic        lk_valid_q, lk_valid_d;
  logic        ready_q, ready_d;
  logic [1:0]  rq_q, rq_d;
  logic [15:0] drop_q, drop_d;
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum;
  logic        acc;
  logic        mismatch;

  // Next-state, field capture, filtering and searcher handshake
  always_comb begin
    state_d  = state_q;
    off_d    = off_q;
    cnt_d    = cnt_q;
    bad_d    = bad_q;
    et_hi_d  = et_hi_q;
    tup_d    = tup_q;
    lk_id_d  = lk_id_q;
    lk_err_d = lk_err_q;
    drop_inc = 2'd0;
    acc      = hp.hp_in_valid && ready_q;
    mismatch = ((off_q == OFF_ETYPE_LO) && ({et_hi_q, hp.hp_in_data} != ETHERTYPE_IPV4)) ||
               ((off_q == OFF_VER_IHL)  && (hp.hp_in_data != IP_VER_IHL)) ||
               ((off_q == OFF_PROTO)    && (hp.hp_in_data != PROTO_TCP));

    unique case (state_q)
      HP_IDLE: begin
        if (acc && hp.hp_in_sof) begin
          off_d = 8'd1;
          bad_d = 1'b0;
          if (hp.hp_in_eof) drop_inc = 2'd1;
          else              state_d  = HP_HDR;
        end
      end
      HP_HDR, HP_SKIP: begin
        if (acc && hp.hp_in_sof) begin
          // A new frame preempts the current one, which is lost
          off_d    = 8'd1;
          bad_d    = 1'b0;
          drop_inc = 2'd1;
          state_d  = HP_HDR;
          if (hp.hp_in_eof) begin
            drop_inc = 2'd2;
            state_d  = HP_IDLE;
          end
        end else if (acc && state_q == HP_SKIP) begin
          if (hp.hp_in_eof) begin
            if (bad_q) begin
              drop_inc = 2'd1;
              state_d  = HP_IDLE;
            end else begin
              cnt_d   = 8'd0;
              state_d = HP_SETUP;
            end
          end
        end else if (acc) begin
          off_d = off_q + 8'd1;
          if (off_q == OFF_ETYPE_HI) et_hi_d = hp.hp_in_data;
          if (in_field(off_q, OFF_MAC_DST, OFF_MAC_DST_LO))
            tup_d.mac_dst = {tup_q.mac_dst[15:0], hp.hp_in_data};
          if (in_field(off_q, OFF_MAC_SRC, OFF_MAC_SRC_LO))
            tup_d.mac_src = {tup_q.mac_src[15:0], hp.hp_in_data};
          if (in_field(off_q, OFF_IP_SRC, OFF_IP_SRC_LO))
            tup_d.ip_src = {tup_q.ip_src[23:0], hp.hp_in_data};
          if (in_field(off_q, OFF_IP_DST, OFF_IP_DST_LO))
            tup_d.ip_dst = {tup_q.ip_dst[23:0], hp.hp_in_data};
          if (in_field(off_q, OFF_PORT_SRC, OFF_PORT_SRC_LO))
            tup_d.port_src = {tup_q.port_src[7:0], hp.hp_in_data};
          if (in_field(off_q, OFF_PORT_DST, OFF_PORT_DST_LO))
            tup_d.port_dst = {tup_q.port_dst[7:0], hp.hp_in_data};

          if (mismatch) begin
            bad_d = 1'b1;
            if (hp.hp_in_eof) begin
              drop_inc = 2'd1;
              state_d  = HP_IDLE;
            end else begin
              state_d  = HP_SKIP;
            end
          end else if (off_q == OFF_PORT_DST_LO) begin
            cnt_d   = 8'd0;
            state_d = hp.hp_in_eof ? HP_SETUP : HP_SKIP;
          end else if (hp.hp_in_eof) begin
            drop_inc = 2'd1;
            state_d  = HP_IDLE;
          end
        end
      end
      HP_SETUP: begin
        // Only quiet cycles (searcher not signalling done) count toward setup
        if (hp.hp_rs_done) begin
          cnt_d = 8'd0;
        end else if (cnt_q == SETUP_LAST) begin
          cnt_d   = 8'd0;
          state_d = HP_REQ;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HP_REQ: begin
        if (hp.hp_rs_done) begin
          lk_id_d  = hp.hp_rs_id;
          lk_err_d = hp.hp_rs_error;
          state_d  = HP_RESP;
        end else if (cnt_q == TIMEOUT_LAST) begin
          lk_id_d  = 8'h00;
          lk_err_d = 8'hFF;
          state_d  = HP_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HP_RESP: state_d = HP_IDLE;
      default: state_d = HP_IDLE;
    endcase

    drop_sum   = {1'b0, drop_q} + {15'd0, drop_inc};
    drop_d     = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    ready_d    = (state_d == HP_IDLE) || (state_d == HP_HDR) || (state_d == HP_SKIP);
    rq_d       = (state_d == HP_REQ) ? RQ_OPEN : RQ_IDLE;
    lk_valid_d = (state_d == HP_RESP);
  end

  // State and output registers
  always_ff @(posedge hp_clk or negedge hp_rst_n) begin
    if (!hp_rst_n) begin
      state_q    <= HP_IDLE;
      off_q      <= 8'd0;
      cnt_q      <= 8'd0;
      bad_q      <= 1'b0;
      et_hi_q    <= 8'd0;
      tup_q      <= '0;
      lk_id_q    <= 8'd0;
      lk_err_q   <= 8'd0;
      lk_valid_q <= 1'b0;
      ready_q    <= 1'b1;
      rq_q       <= RQ_IDLE;
      drop_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      cnt_q      <= cnt_d;
      bad_q      <= bad_d;
      et_hi_q    <= et_hi_d;
      tup_q      <= tup_d;
      lk_id_q    <= lk_id_d;
      lk_err_q   <= lk_err_d;
      lk_valid_q <= lk_valid_d;
      ready_q    <= ready_d;
      rq_q       <= rq_d;
      drop_q     <= drop_d;
    end
  end

  assign hp.hp_in_ready = ready_q;
  assign hp.hp_rq       = rq_q;
  assign hp.hp_mac_src  = tup_q.mac_src;
  assign hp.hp_mac_dst  = tup_q.mac_dst;
  assign hp.hp_ip_src   = tup_q.ip_src;
  assign hp.hp_ip_dst   = tup_q.ip_dst;
  assign hp.hp_port_src = tup_q.port_src;
  assign hp.hp_port_dst = tup_q.port_dst;
  assign hp.hp_lk_valid = lk_valid_q;
  assign hp.hp_lk_id    = lk_id_q;
  assign hp.hp_lk_err   = lk_err_q;
  assign hp.hp_drop_cnt = drop_q;

endmodule

// File: tb/tb_tcp_hdr_parser.sv
// tb/tb_tcp_hdr_parser.sv - self-checking bench for tcp_hdr_parser
module tb_tcp_hdr_parser;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tcp_hdr_parser_if hp_if ();

  tcp_hdr_parser #(.SETUP_CYC(2), .TIMEOUT_CYC(255)) dut (
    .hp_clk   (clk),
    .hp_rst_n (rst_n),
    .hp       (hp_if)
  );

  int         checks = 0;
  int         errors = 0;
  int         exp_drop = 0;
  bit         not_ready_seen = 0;
  logic [7:0] frm[$];

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [143:0] tuple_obs();
    return {hp_if.hp_mac_src, hp_if.hp_mac_dst, hp_if.hp_ip_src, hp_if.hp_ip_dst,
            hp_if.hp_port_src, hp_if.hp_port_dst};
  endfunction

  // Reference model: a frame is looked up iff it is long enough and the three filter fields match
  function automatic bit model_good();
    if (frm.size() < 38) return 0;
    return ({frm[12], frm[13]} == 16'h0800) && (frm[14] == 8'h45) && (frm[23] == 8'h06);
  endfunction

  function automatic logic [143:0] model_tuple();
    return {frm[9], frm[10], frm[11], frm[3], frm[4], frm[5],
            frm[26], frm[27], frm[28], frm[29], frm[30], frm[31], frm[32], frm[33],
            frm[34], frm[35], frm[36], frm[37]};
  endfunction

  task automatic build(input logic [47:0] md, input logic [47:0] ms, input logic [15:0] et,
                       input logic [7:0] vi, input logic [7:0] pr, input logic [31:0] ips,
                       input logic [31:0] ipd, input logic [15:0] ps, input logic [15:0] pd,
                       input int extra);
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(md[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(ms[47-8*i -: 8]);
    frm.push_back(et[15:8]); frm.push_back(et[7:0]);
    frm.push_back(vi);
    for (int i = 15; i < 23; i++) frm.push_back(8'($urandom));
    frm.push_back(pr);
    frm.push_back(8'($urandom)); frm.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) frm.push_back(ips[31-8*i -: 8]);
    for (int i = 0; i < 4; i++) frm.push_back(ipd[31-8*i -: 8]);
    frm.push_back(ps[15:8]); frm.push_back(ps[7:0]);
    frm.push_back(pd[15:8]); frm.push_back(pd[7:0]);
    for (int i = 0; i < 16 + extra; i++) frm.push_back(8'($urandom));
  endtask

  task automatic build_rand_good();
    build({$urandom, $urandom}, {$urandom, $urandom}, 16'h0800, 8'h45, 8'h06,
          $urandom, $urandom, 16'($urandom), 16'($urandom), int'($urandom_range(0, 8)));
  endtask

  task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
    int n;
    @(negedge clk);
    n = 0;
    while (!hp_if.hp_in_ready && n < 50) begin
      not_ready_seen = 1;
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_wait_expired", 0, 1);
    hp_if.hp_in_data  = d;
    hp_if.hp_in_sof   = s;
    hp_if.hp_in_eof   = e;
    hp_if.hp_in_valid = 1'b1;
  endtask

  task automatic end_stream();
    @(negedge clk);
    hp_if.hp_in_valid = 1'b0;
    hp_if.hp_in_sof   = 1'b0;
    hp_if.hp_in_eof   = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit with_eof);
    for (int i = 0; i < n; i++)
      send_byte(frm[i], i == 0, with_eof && (i == n - 1));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, hp_if.hp_in_ready, 1);
    chk({tag, "_rq"}, hp_if.hp_rq, 0);
    chk({tag, "_lk_valid"}, hp_if.hp_lk_valid, 0);
    chk({tag, "_lk_id_err"}, {hp_if.hp_lk_id, hp_if.hp_lk_err}, 0);
    chk({tag, "_drop"}, hp_if.hp_drop_cnt, 0);
    chk({tag, "_tuple"}, tuple_obs(), 0);
  endtask

  // Waits for hp_rq, then plays the searcher; lat==0 means never answer
  task automatic lookup(input int lat, input logic [7:0] rid, input logic [7:0] rerr,
                        input logic [143:0] et);
    logic [143:0] prev;
    int stable, n, cyc;
    bit up;
    prev = tuple_obs(); stable = 0; n = 0; up = 0;
    while (!up && n < 20) begin
      @(negedge clk);
      n++;
      if (tuple_obs() === prev) stable++; else stable = 0;
      prev = tuple_obs();
      if (hp_if.hp_rq == 2'b01) up = 1;
    end
    chk("rq_rise", up, 1);
    chk("tuple_at_rq", tuple_obs(), et);
    chk("tuple_stable_before_rq", stable >= 2, 1);
    chk("ready_low_in_req", hp_if.hp_in_ready, 0);
    if (lat > 0) begin
      repeat (lat - 1) @(negedge clk);
      chk("rq_held", hp_if.hp_rq, 2'b01);
      hp_if.hp_rs_done  = 1'b1;
      hp_if.hp_rs_id    = rid;
      hp_if.hp_rs_error = rerr;
      @(negedge clk);
      hp_if.hp_rs_done = 1'b0;
      chk("lk_valid", hp_if.hp_lk_valid, 1);
      chk("lk_id", hp_if.hp_lk_id, rid);
      chk("lk_err", hp_if.hp_lk_err, rerr);
      chk("rq_fall", hp_if.hp_rq, 0);
    end else begin
      cyc = 1;
      while (cyc < 400) begin
        @(negedge clk);
        if (hp_if.hp_rq == 2'b01) cyc++;
        else break;
      end
      chk("timeout_req_cycles", cyc, 255);
      chk("timeout_lk_valid", hp_if.hp_lk_valid, 1);
      chk("timeout_lk_id", hp_if.hp_lk_id, 0);
      chk("timeout_lk_err", hp_if.hp_lk_err, 8'hFF);
      chk("timeout_rq_fall", hp_if.hp_rq, 0);
    end
    @(negedge clk);
    chk("lk_valid_one_cycle", hp_if.hp_lk_valid, 0);
    chk("ready_after_resp", hp_if.hp_in_ready, 1);
  endtask

  task automatic run_frame(input int lat, input logic [7:0] rid, input logic [7:0] rerr);
    bit rq_seen;
    send_frame(frm.size(), 1);
    end_stream();
    if (model_good()) begin
      lookup(lat, rid, rerr, model_tuple());
    end else begin
      exp_drop++;
      chk("ready_after_drop", hp_if.hp_in_ready, 1);
      rq_seen = 0;
      repeat (6) begin
        @(negedge clk);
        if (hp_if.hp_rq != 2'b00) rq_seen = 1;
      end
      chk("no_rq_for_drop", rq_seen, 0);
    end
    chk("drop_cnt", hp_if.hp_drop_cnt, exp_drop);
  endtask

  initial begin
    int kind, n;
    logic [15:0] et;
    logic [7:0] vi, pr;
    hp_if.hp_in_data  = 8'd0;
    hp_if.hp_in_valid = 1'b0;
    hp_if.hp_in_sof   = 1'b0;
    hp_if.hp_in_eof   = 1'b0;
    hp_if.hp_rs_done  = 1'b0;
    hp_if.hp_rs_id    = 8'd0;
    hp_if.hp_rs_error = 8'd0;

    @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // Good SYN frame
    build(48'h112233445566, 48'h020000AABBCC, 16'h0800, 8'h45, 8'h06,
          32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, 0);
    run_frame(5, 8'h03, 8'h03);
    chk("syn_mac_src", hp_if.hp_mac_src, 24'hAABBCC);
    chk("syn_ip_src", hp_if.hp_ip_src, 32'h0A000001);
    chk("syn_port_src", hp_if.hp_port_src, 16'h04D2);
    chk("syn_port_dst", hp_if.hp_port_dst, 16'h0050);

    // IPv6 ethertype: dropped, ready never deasserts
    build(48'h1, 48'h2, 16'h86DD, 8'h45, 8'h06, 32'h1, 32'h2, 16'h3, 16'h4, 2);
    not_ready_seen = 0;
    run_frame(1, 8'h00, 8'h00);
    chk("ipv6_ready_through_eof", not_ready_seen, 0);
    chk("ipv6_drop_is_one", hp_if.hp_drop_cnt, 1);

    // UDP then a good frame
    build({$urandom, $urandom}, {$urandom, $urandom}, 16'h0800, 8'h45, 8'h11,
          $urandom, $urandom, 16'($urandom), 16'($urandom), 0);
    run_frame(1, 8'h00, 8'h00);
    build_rand_good();
    run_frame(3, 8'h5A, 8'h00);

    // Short frame (eof at byte 30), then a frame cut at byte 20 by a new sof
    build_rand_good();
    while (frm.size() > 31) void'(frm.pop_back());
    run_frame(1, 8'h00, 8'h00);
    build_rand_good();
    send_frame(20, 0);
    exp_drop++;
    build_rand_good();
    run_frame(4, 8'hC1, 8'h07);

    // Searcher never answers
    build_rand_good();
    run_frame(0, 8'h00, 8'h00);

    // Reset pulsed while the request is pending
    build_rand_good();
    send_frame(frm.size(), 1);
    end_stream();
    n = 0;
    while (hp_if.hp_rq != 2'b01 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_test_rq_rise", hp_if.hp_rq, 2'b01);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreq_reset");
    exp_drop = 0;
    @(negedge clk);
    rst_n = 1'b1;
    build_rand_good();
    run_frame(2, 8'h77, 8'h01);

    // Randomized mix of good, filtered and short frames
    for (int it = 0; it < 14; it++) begin
      kind = int'($urandom_range(0, 4));
      et = 16'h0800; vi = 8'h45; pr = 8'h06;
      if (kind == 1) begin et = 16'($urandom); if (et == 16'h0800) et = 16'h86DD; end
      if (kind == 2) begin vi = 8'($urandom); if (vi == 8'h45) vi = 8'h46; end
      if (kind == 3) begin pr = 8'($urandom); if (pr == 8'h06) pr = 8'h11; end
      build({$urandom, $urandom}, {$urandom, $urandom}, et, vi, pr,
            $urandom, $urandom, 16'($urandom), 16'($urandom), int'($urandom_range(0, 6)));
      if (kind == 4) begin
        n = int'($urandom_range(1, 37));
        while (frm.size() > n) void'(frm.pop_back());
      end
      run_frame(int'($urandom_range(1, 6)), 8'($urandom), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
